// File: rtl/mem_access.sv
// Memory-stage data access unit: issues aligned loads/stores over a
// req/ready/rvalid handshake and stalls the pipeline while one is outstanding.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_ext_un,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_rs2_data,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] me_alu_result,
  output logic [63:0] me_mem_data,
  output logic        me_mem_to_reg,
  output logic        me_mem_ext_un,
  output logic [7:0]  me_mem_byte_enable,
  output logic        me_exception_flag,
  output logic [4:0]  me_exception_cause,
  output logic        stall_req
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  be_base, be;
  logic [63:0] wdata_sh;
  logic        misaligned, is_mem, start, flush_pend;

  always_comb begin
    be_base    = 8'h01;
    misaligned = 1'b0;
    case (ex_mem_size)
      2'd0: begin be_base = 8'h01; misaligned = 1'b0; end
      2'd1: begin be_base = 8'h03; misaligned = ex_alu_result[0]; end
      2'd2: begin be_base = 8'h0F; misaligned = |ex_alu_result[1:0]; end
      default: begin be_base = 8'hFF; misaligned = |ex_alu_result[2:0]; end
    endcase
  end

  assign be       = be_base << ex_alu_result[2:0];
  assign wdata_sh = ex_rs2_data << {ex_alu_result[2:0], 3'b000};
  assign is_mem   = ex_mem_read | ex_mem_write;
  assign start    = ex_valid & is_mem & ~misaligned & ~flush;

  assign me_alu_result      = ex_alu_result;
  assign me_mem_ext_un      = ex_mem_ext_un;
  assign me_mem_byte_enable = be;
  assign me_mem_to_reg      = ex_mem_read & ~misaligned;
  assign me_exception_flag  = ex_valid & is_mem & misaligned;
  assign me_exception_cause = !me_exception_flag ? 5'd0 :
                              ex_mem_read        ? 5'd4 : 5'd6;

  assign stall_req = ((state == IDLE) & start) | (state == REQ) | (state == WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (dmem_ready)  state_nxt = WAIT;
        else if (flush)  state_nxt = IDLE;
      end
      WAIT: if (dmem_rvalid) state_nxt = (flush_pend | flush) ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wstrb  <= '0;
      me_mem_data <= '0;
      flush_pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          dmem_req   <= 1'b1;
          dmem_we    <= ex_mem_write;
          dmem_addr  <= {ex_alu_result[63:3], 3'b000};
          dmem_wdata <= wdata_sh;
          dmem_wstrb <= be;
        end
        REQ: begin
          if (dmem_ready | flush) dmem_req <= 1'b0;
          // A flush coincident with acceptance still owes us a response to drain.
          if (dmem_ready & flush) flush_pend <= 1'b1;
        end
        WAIT: begin
          if (flush) flush_pend <= 1'b1;
          if (dmem_rvalid) begin
            if (!(flush_pend | flush) && !dmem_we) me_mem_data <= dmem_rdata;
            flush_pend <= 1'b0;
          end
        end
        default: flush_pend <= 1'b0;
      endcase
    end
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage data access unit. It sits between the EX/MEM pipeline register and the MEM/WB register (`me_wb`) and produces the `me_*` signals that register captures. It issues loads and stores to data memory over a req/ready/rvalid handshake and requests pipeline stall while an access is outstanding. Raw 64-bit read data plus byte enable and extension flag go downstream; byte extraction and sign extension happen in writeback.

## Interface
- No parameters. Data width fixed at 64 (`REG_BUS`).
- `clk` in 1: clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: instruction in MEM stage is valid.
- `ex_mem_read` in 1: load.
- `ex_mem_write` in 1: store. Never asserted together with `ex_mem_read`.
- `ex_mem_size` in 2: 0=byte, 1=half, 2=word, 3=dword.
- `ex_mem_ext_un` in 1: load is unsigned.
- `ex_alu_result` in 64: effective address, or ALU result for non-memory instructions.
- `ex_rs2_data` in 64: store data, right-aligned.
- `flush` in 1: kill the current instruction.
- `dmem_req` out 1: request valid (registered).
- `dmem_we` out 1: 1=store.
- `dmem_addr` out 64: `{addr[63:3],3'b0}`.
- `dmem_wdata` out 64: store data shifted to its byte lane.
- `dmem_wstrb` out 8: byte strobes.
- `dmem_ready` in 1: memory accepts the request this cycle.
- `dmem_rvalid` in 1: response (read data or write ack).
- `dmem_rdata` in 64: read data.
- `me_alu_result` out 64: pass-through of `ex_alu_result`.
- `me_mem_data` out 64: captured raw read word.
- `me_mem_to_reg` out 1: writeback selects memory data.
- `me_mem_ext_un` out 1: pass-through.
- `me_mem_byte_enable` out 8: same value as the strobes.
- `me_exception_flag` out 1; `me_exception_cause` out 5.
- `stall_req` out 1: hold upstream stages and bubble `me_wb`.

## Operation
- `start` = `ex_valid & (ex_mem_read | ex_mem_write) & aligned & ~flush`.
- Alignment: half needs `addr[0]=0`; word needs `addr[1:0]=0`; dword needs `addr[2:0]=0`. Byte accesses are always aligned.
- Misaligned valid access: `me_exception_flag=1`, cause 4 for a load or 6 for a store. No bus access and no stall. `me_mem_to_reg=0`.
- Byte enable is shifted left by `addr[2:0]`: byte 8'h01, half 8'h03, word 8'h0F, dword 8'hFF.
- `dmem_wdata = ex_rs2_data << (8*addr[2:0])`.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: when `start`, go to REQ and latch we/addr/wdata/wstrb.
  - REQ: `dmem_req=1`. On `dmem_ready`, go to WAIT. On `flush` without `dmem_ready`, go to IDLE.
  - WAIT: on `dmem_rvalid`, capture `dmem_rdata` into `me_mem_data` (loads only) and go to DONE, or to IDLE if a flush was recorded during WAIT.
  - DONE: 1 cycle, then IDLE.
- `stall_req = (IDLE & start) | REQ | WAIT`. It is 0 in DONE, so `me_wb` captures the result at the end of DONE.
- Non-memory or invalid instructions pass through combinationally with no stall.
- `me_mem_to_reg = ex_mem_read & ~misaligned`.

## Timing
- Reset values: state IDLE, `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`, `dmem_wstrb=0`, `me_mem_data=0`, pending-flush flag 0. Combinational `me_*` outputs follow their inputs.
- Minimum access with ready and rvalid each 1 cycle after the previous phase: IDLE (stall) → REQ → WAIT → DONE. That is 3 stall cycles, with the result available in cycle 4.
- `dmem_req` and the address, data and strobe outputs stay stable from REQ entry until `dmem_ready`.
- At most one outstanding request. `dmem_rvalid` outside WAIT is ignored.
- A flush in WAIT cannot cancel the bus transaction. The response is consumed and discarded, and `me_mem_data` is not updated.
- `rst` mid-access: go to IDLE next edge and drop `dmem_req`. The memory side drops any in-flight response on reset.

## Test plan
- Load dword from 0x80000008, ready and rvalid immediate, rdata 0x1122334455667788 → `stall_req` high 3 cycles. DONE shows `me_mem_data=0x1122334455667788`, `me_mem_byte_enable=8'hFF`, `me_mem_to_reg=1`.
- Store byte 0xAB to 0x80000005 → `dmem_addr=0x80000000`, `dmem_wstrb=8'h20`, `dmem_wdata[47:40]=0xAB`, `dmem_we=1`, `me_mem_to_reg=0`.
- Load half from 0x80000003 → `me_exception_flag=1`, cause 4, `dmem_req` never asserted, `stall_req=0`. The same case as a store gives cause 6.
- `dmem_ready` low for 5 cycles → request and address held constant, `stall_req` high throughout. After ready, normal completion.
- Flush in WAIT, rvalid 2 cycles later → FSM returns to IDLE without DONE, and `me_mem_data` is unchanged.
- `rst` asserted in REQ → next cycle IDLE, `dmem_req=0`, `stall_req=0`, `me_mem_data=0`.
